decoder_nscan: RTL
==================

Name: decoder_nscan

Overview:
- Parametrised N-to-2^N one-hot decoder with a registered output.
- Generalises the fixed 2x4 enable decoder in code width.
- Adds an auto-scan mode: an internal index sweeps all outputs with a programmable dwell, e.g. for multiplexed display digit or row strobes.
- Sits between control logic and any one-hot select or strobe bus.

Parameters:
- N, 2, input code width; output width is 2^N (N >= 1).
- DWELL_W, 4, width of the dwell-count input.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  enable; 0 forces d to all-zero
- mode  input  1  0 = direct decode of e; 1 = auto-scan
- e  input  N  code to decode in direct mode
- dwell  input  DWELL_W  scan mode: each output is held for dwell+1 cycles
- d  output  2^N  registered one-hot (or all-zero) output
- idx  output  N  index currently driven on d
- valid  output  1  high when d holds a live one-hot value
- wrap  output  1  one-cycle pulse when the scan index wraps from 2^N-1 to 0

Behaviour:
- Reset (async assert, sync release): d=0, idx=0, valid=0, wrap=0; internal dwell counter dcnt=0; scan state = IDLE.
- All outputs are registered. Nothing is combinational from input to output.

Direct mode (mode=0):
- Latency is 1 cycle: d <= en ? (1 << e) : 0; idx <= e; valid <= en; wrap <= 0.
- dcnt is held at 0.
- Exactly one bit of d is high whenever valid=1.

Scan mode (mode=1), states IDLE and RUN:
- IDLE -> RUN on the first cycle with mode=1 and en=1. On that edge: idx <= 0, d <= 1, valid <= 1, dcnt <= 0.
- RUN, en=1, dcnt < dwell: dcnt <= dcnt+1; d and idx are held.
- RUN, en=1, dcnt >= dwell: dcnt <= 0; idx <= idx+1 (mod 2^N); d <= 1 << (idx+1).
  - wrap <= 1 when idx was 2^N-1; otherwise wrap <= 0.
- RUN, en=0: scan is frozen. d <= 0, valid <= 0, wrap <= 0; idx and dcnt are held.
  - When en returns to 1, d <= 1 << idx, valid <= 1, and the dwell count resumes from the held dcnt.
- dwell is sampled every cycle. Lowering dwell below the current dcnt causes a step on the next cycle (>= comparison).
- dwell=0 steps every cycle, so wrap pulses every 2^N cycles.

Mode switches and reset:
- mode 1->0: state <= IDLE; direct decode takes effect on the same edge.
- mode 0->1: the scan always restarts at idx=0 and never inherits the direct-mode idx.
- wrap is never high in direct mode, IDLE, or while en=0.
- Reset asserted mid-scan clears all state immediately, with no clock needed. After release the block waits in IDLE.

Width rules:
- dcnt is DWELL_W bits.
- idx arithmetic wraps naturally at N bits.
- Shift results are 2^N bits wide.

Test Plan:
- N=2, mode=0, en=1, e=00,01,10,11 on successive cycles -> d=0001,0010,0100,1000, each one cycle after its e; valid=1; idx follows e.
- N=2, mode=0, e=11, en drops to 0 -> next cycle d=0000, valid=0. en back to 1 -> d=1000.
- N=2, mode=1, en=1, dwell=2 -> d sequence 0001 x3 cycles, 0010 x3, 0100 x3, 1000 x3, 0001. wrap is high for exactly the one cycle d returns to 0001.
- N=2, mode=1, dwell=0 -> d rotates every cycle; wrap pulses every 4 cycles.
- Scan with dwell=3, at idx=2 and dcnt=1, en=0 for 5 cycles -> d=0000, valid=0, idx stays 2. After en=1, d=0100 for the remaining 3 cycles (dcnt 1,2,3), then d=1000.
- Assert rst asynchronously mid-scan between clock edges -> d=0, idx=0, valid=0, wrap=0 immediately. After release, mode=1, en=1 -> scan restarts at d=0001.
- Parameter sweep N=3, DWELL_W=2, dwell=1, mode=1 -> 8-bit one-hot walks bits 0..7, 2 cycles each; wrap fires every 16 cycles.

Source files
------------

// File: rtl/decoder_nscan.sv
// decoder_nscan: N-to-2^N one-hot decoder with registered outputs and an
// auto-scan mode that sweeps every output with a programmable dwell time.
module decoder_nscan #(
  parameter int N       = 2,
  parameter int DWELL_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        e,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [(1<<N)-1:0]   d,
  output logic [N-1:0]        idx,
  output logic                valid,
  output logic                wrap
);

  localparam int M = 1 << N;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [M-1:0]       d_q, d_d;
  logic [N-1:0]       idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [N-1:0]       idx_inc;

  function automatic logic [M-1:0] onehot(input logic [N-1:0] i);
    logic [M-1:0] one;
    one = {{(M-1){1'b0}}, 1'b1};
    return one << i;
  endfunction

  assign idx_inc = idx_q + N'(1);

  // Next-state and next-output logic for direct decode and the scan FSM
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    dcnt_d  = dcnt_q;
    if (!mode) begin
      // Direct decode; leaving scan drops the FSM back to IDLE so the next
      // scan entry always restarts at index 0.
      state_d = IDLE;
      d_d     = en ? onehot(e) : '0;
      idx_d   = e;
      valid_d = en;
      dcnt_d  = '0;
    end else if (state_q == IDLE) begin
      d_d     = '0;
      valid_d = 1'b0;
      dcnt_d  = '0;
      if (en) begin
        state_d = RUN;
        idx_d   = '0;
        d_d     = onehot('0);
        valid_d = 1'b1;
      end
    end else if (!en) begin
      // Frozen: blank the output, keep position and dwell count.
      d_d     = '0;
      valid_d = 1'b0;
    end else if (!valid_q) begin
      // First enabled cycle after a freeze: re-light the held index; the
      // dwell count carries on from where it stopped.
      d_d     = onehot(idx_q);
      valid_d = 1'b1;
    end else if (dcnt_q >= dwell) begin
      // >= so that lowering dwell below the running count still steps.
      dcnt_d  = '0;
      idx_d   = idx_inc;
      d_d     = onehot(idx_inc);
      wrap_d  = (idx_q == {N{1'b1}});
    end else begin
      dcnt_d  = dcnt_q + DWELL_W'(1);
    end
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign d     = d_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule
